exp6_unidade_controle: RTL and testbench
========================================

// Module: exp6_unidade_controle
// PURPOSE
//  Moore FSM sequencing the exp6 game datapath (Genius-style memory game): shows the ROM sequence
//  round by round on LEDs/buzzer, then collects and checks player moves with optional timeout.
//  Drives every datapath control input; consumes every condition output; reports game result.
// PARAMETERS
//  TIMEOUT_EN  1  0: timeout is never raised, whatever nivel_tempo_reg is (contaTempo held 0)
// PORTS
//  clock               in  1  system clock; all state changes on rising edge
//  reset               in  1  asynchronous, active-low; forces INICIAL
//  iniciar             in  1  start/restart request, level, sampled each clock
//  jogada_feita        in  1  1-cycle pulse: button press detected
//  jogada_correta      in  1  registered move == ROM word at current address
//  enderecoIgualRodada in  1  address counter == round counter
//  nivel_jogadas_reg   in  1  0: 8-round game (ends at meioCR); 1: 16-round game (ends at fimCR)
//  nivel_tempo_reg     in  1  1: move timeout enabled
//  meioCR, fimCR       in  1  round counter at half / last value
//  meioTM, fimTM       in  1  display timer half / end
//  fimTempo            in  1  move timeout timer end
//  zeraR registraR zeraC contaC registraN contaTempo zeraCR zeraTempo contaCR zeraTM contaTM
//                      out 1  datapath controls, Moore-decoded (table below)
//  ativa_leds, toca    out 1  gate LEDs / enable buzzer
//  pronto              out 1  game finished (any terminal state)
//  ganhou, perdeu, timeout out 1  result flags, valid while pronto=1
//  db_estado           out 5  current state code
// BEHAVIOUR
//  Reset: state INICIAL (0); all outputs 0; db_estado=0. Async assert, sync release.
//  All outputs depend only on state; asserted signals per state, all others 0:
//   0 INICIAL     : none.                    iniciar -> PREPARA
//   1 PREPARA     : zeraR zeraC zeraCR zeraTM zeraTempo.  -> REG_NIVEL
//   2 REG_NIVEL   : registraN.               -> INICIO_RODADA
//   3 INICIO_ROD  : zeraC zeraTM.            -> MOSTRA
//   4 MOSTRA      : ativa_leds toca contaTM. meioTM -> APAGA
//   5 APAGA       : contaTM.  fimTM & enderecoIgualRodada -> ZERA_JOG; fimTM & !eq -> PROX_LED
//   6 PROX_LED    : contaC zeraTM.           -> MOSTRA
//   7 ZERA_JOG    : zeraC zeraTempo.         -> ESPERA
//   8 ESPERA      : contaTempo iff TIMEOUT_EN & nivel_tempo_reg.
//                   jogada_feita -> REGISTRA; else fimTempo & timeout enabled -> TIMEOUT
//   9 REGISTRA    : registraR.               -> COMPARA
//  10 COMPARA     : none. !jogada_correta -> ERROU; correct & eq -> FIM_RODADA; correct & !eq -> PROX_JOG
//  11 PROX_JOG    : contaC zeraTempo.        -> ESPERA
//  12 FIM_RODADA  : none. last = nivel_jogadas_reg ? fimCR : meioCR; last -> ACERTOU else PROX_RODADA
//  13 PROX_RODADA : contaCR.                 -> INICIO_ROD
//  14 ACERTOU     : pronto ganhou.           iniciar -> PREPARA
//  15 ERROU       : pronto perdeu.           iniciar -> PREPARA
//  16 TIMEOUT     : pronto perdeu timeout.   iniciar -> PREPARA
//  Unlisted conditions: hold state. Codes 17..31: next state INICIAL, outputs 0.
//  Priority: jogada_feita over fimTempo in same ESPERA cycle; iniciar ignored in states 1..13.
//  Round r (0-based) shows r+1 LEDs, then accepts r+1 moves; each LED on for meioTM, off till fimTM.
//  Level inputs sampled only in REG_NIVEL; changes mid-game have no effect until next start.
//  reset low at any time (incl. MOSTRA with buzzer on) -> INICIAL immediately, toca/ativa_leds drop same instant.
// TESTING
//  T1 reset low then high, iniciar=0 20 cycles -> db_estado=0, all outputs 0.
//  T2 iniciar 1 cycle -> states 1,2,3,4; zeraR/zeraCR high exactly 1 cycle, registraN 1 cycle.
//  T3 level 0, always correct moves -> 8 rounds, contaCR pulses 7 times, ends state 14, ganhou=1.
//  T4 round 2, wrong 2nd move -> COMPARA->ERROU(15), perdeu=1, timeout=0; iniciar -> PREPARA.
//  T5 nivel_tempo=1, no press in ESPERA until fimTempo -> state 16, timeout=perdeu=1; nivel_tempo=0 -> stays 8.
//  T6 jogada_feita & fimTempo same cycle -> REGISTRA(9); reset low during MOSTRA -> state 0, toca=0 async.

Source files
------------

// File: rtl/exp6_unidade_controle.sv
// Control unit for the exp6 memory game: a Moore FSM that plays the stored
// sequence round by round on LEDs/buzzer, then collects and checks the
// player's moves, with an optional per-move timeout. All outputs are decoded
// from the current state only; db_estado exposes the state code.
//
// Input semantics: jogada_feita is a one-cycle pulse per button press. All
// other condition inputs are levels sampled on the rising clock edge.
module exp6_unidade_controle #(
   parameter bit TIMEOUT_EN = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada_feita,
   input  logic       jogada_correta,
   input  logic       enderecoIgualRodada,
   input  logic       nivel_jogadas_reg,
   input  logic       nivel_tempo_reg,
   input  logic       meioCR,
   input  logic       fimCR,
   input  logic       meioTM,
   input  logic       fimTM,
   input  logic       fimTempo,
   output logic       zeraR,
   output logic       registraR,
   output logic       zeraC,
   output logic       contaC,
   output logic       registraN,
   output logic       contaTempo,
   output logic       zeraCR,
   output logic       zeraTempo,
   output logic       contaCR,
   output logic       zeraTM,
   output logic       contaTM,
   output logic       ativa_leds,
   output logic       toca,
   output logic       pronto,
   output logic       ganhou,
   output logic       perdeu,
   output logic       timeout,
   output logic [4:0] db_estado
);

   typedef enum logic [4:0] {
      INICIAL     = 5'd0,
      PREPARA     = 5'd1,
      REG_NIVEL   = 5'd2,
      INICIO_ROD  = 5'd3,
      MOSTRA      = 5'd4,
      APAGA       = 5'd5,
      PROX_LED    = 5'd6,
      ZERA_JOG    = 5'd7,
      ESPERA      = 5'd8,
      REGISTRA    = 5'd9,
      COMPARA     = 5'd10,
      PROX_JOG    = 5'd11,
      FIM_RODADA  = 5'd12,
      PROX_RODADA = 5'd13,
      ACERTOU     = 5'd14,
      ERROU       = 5'd15,
      TIMEOUT_ST  = 5'd16
   } estado_t;

   estado_t state_q, state_d;

   // Timeout only exists when built in and selected for this game.
   logic tempo_en;
   assign tempo_en = TIMEOUT_EN & nivel_tempo_reg;

   // Which round counter flag marks the final round for the chosen game length.
   logic ultima_rodada;
   assign ultima_rodada = nivel_jogadas_reg ? fimCR : meioCR;

   // State register: async reset drops straight to INICIAL, so LEDs/buzzer
   // go dark the instant reset asserts.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= INICIAL;
      else        state_q <= state_d;
   end

   // Next-state logic; any condition not listed holds the current state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         INICIAL:     if (iniciar) state_d = PREPARA;
         PREPARA:     state_d = REG_NIVEL;
         REG_NIVEL:   state_d = INICIO_ROD;
         INICIO_ROD:  state_d = MOSTRA;
         MOSTRA:      if (meioTM) state_d = APAGA;
         APAGA:       if (fimTM) state_d = enderecoIgualRodada ? ZERA_JOG : PROX_LED;
         PROX_LED:    state_d = MOSTRA;
         ZERA_JOG:    state_d = ESPERA;
         // A press wins over a timeout landing in the same cycle.
         ESPERA: begin
            if (jogada_feita)               state_d = REGISTRA;
            else if (fimTempo && tempo_en)  state_d = TIMEOUT_ST;
         end
         REGISTRA:    state_d = COMPARA;
         COMPARA: begin
            if (!jogada_correta)          state_d = ERROU;
            else if (enderecoIgualRodada) state_d = FIM_RODADA;
            else                          state_d = PROX_JOG;
         end
         PROX_JOG:    state_d = ESPERA;
         FIM_RODADA:  state_d = ultima_rodada ? ACERTOU : PROX_RODADA;
         PROX_RODADA: state_d = INICIO_ROD;
         ACERTOU,
         ERROU,
         TIMEOUT_ST:  if (iniciar) state_d = PREPARA;
         default:     state_d = INICIAL;
      endcase
   end

   // Moore output decode; every output defaults low.
   always_comb begin
      zeraR      = 1'b0;
      registraR  = 1'b0;
      zeraC      = 1'b0;
      contaC     = 1'b0;
      registraN  = 1'b0;
      contaTempo = 1'b0;
      zeraCR     = 1'b0;
      zeraTempo  = 1'b0;
      contaCR    = 1'b0;
      zeraTM     = 1'b0;
      contaTM    = 1'b0;
      ativa_leds = 1'b0;
      toca       = 1'b0;
      pronto     = 1'b0;
      ganhou     = 1'b0;
      perdeu     = 1'b0;
      timeout    = 1'b0;
      case (state_q)
         PREPARA: begin
            zeraR     = 1'b1;
            zeraC     = 1'b1;
            zeraCR    = 1'b1;
            zeraTM    = 1'b1;
            zeraTempo = 1'b1;
         end
         REG_NIVEL:   registraN = 1'b1;
         INICIO_ROD: begin
            zeraC  = 1'b1;
            zeraTM = 1'b1;
         end
         MOSTRA: begin
            ativa_leds = 1'b1;
            toca       = 1'b1;
            contaTM    = 1'b1;
         end
         APAGA:       contaTM = 1'b1;
         PROX_LED: begin
            contaC = 1'b1;
            zeraTM = 1'b1;
         end
         ZERA_JOG: begin
            zeraC     = 1'b1;
            zeraTempo = 1'b1;
         end
         ESPERA:      contaTempo = tempo_en;
         REGISTRA:    registraR = 1'b1;
         PROX_JOG: begin
            contaC    = 1'b1;
            zeraTempo = 1'b1;
         end
         PROX_RODADA: contaCR = 1'b1;
         ACERTOU: begin
            pronto = 1'b1;
            ganhou = 1'b1;
         end
         ERROU: begin
            pronto = 1'b1;
            perdeu = 1'b1;
         end
         TIMEOUT_ST: begin
            pronto  = 1'b1;
            perdeu  = 1'b1;
            timeout = 1'b1;
         end
         default: ;
      endcase
   end

   assign db_estado = state_q;

endmodule

// File: tb/tb_exp6_unidade_controle.sv
// Directed bench for the exp6 control unit. Each step pushes the expected
// state and output vector, advances one clock, then pops and compares.
module tb_exp6_unidade_controle;

   logic clock, reset, iniciar, jogada_feita, jogada_correta, enderecoIgualRodada;
   logic nivel_jogadas_reg, nivel_tempo_reg, meioCR, fimCR, meioTM, fimTM, fimTempo;
   logic zeraR, registraR, zeraC, contaC, registraN, contaTempo, zeraCR, zeraTempo;
   logic contaCR, zeraTM, contaTM, ativa_leds, toca, pronto, ganhou, perdeu, timeout;
   logic [4:0] db_estado;

   logic [16:0] outs;
   logic [21:0] exp_q[$];
   int n_assert = 0;
   int n_fail   = 0;
   int n_cr     = 0;

   exp6_unidade_controle #(.TIMEOUT_EN(1'b1)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
      .jogada_correta(jogada_correta), .enderecoIgualRodada(enderecoIgualRodada),
      .nivel_jogadas_reg(nivel_jogadas_reg), .nivel_tempo_reg(nivel_tempo_reg),
      .meioCR(meioCR), .fimCR(fimCR), .meioTM(meioTM), .fimTM(fimTM), .fimTempo(fimTempo),
      .zeraR(zeraR), .registraR(registraR), .zeraC(zeraC), .contaC(contaC),
      .registraN(registraN), .contaTempo(contaTempo), .zeraCR(zeraCR),
      .zeraTempo(zeraTempo), .contaCR(contaCR), .zeraTM(zeraTM), .contaTM(contaTM),
      .ativa_leds(ativa_leds), .toca(toca), .pronto(pronto), .ganhou(ganhou),
      .perdeu(perdeu), .timeout(timeout), .db_estado(db_estado)
   );

   assign outs = {zeraR, registraR, zeraC, contaC, registraN, contaTempo, zeraCR, zeraTempo,
                  contaCR, zeraTM, contaTM, ativa_leds, toca, pronto, ganhou, perdeu, timeout};

   // Clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Watchdog
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected outputs per state, taken from the state/output table.
   function automatic logic [16:0] exp_outs(input logic [4:0] s, input logic t_en);
      logic zr, rr, zc, cc, rn, ct, zcr, zt, ccr, ztm, ctm, al, tc, pr, ga, pe, tmo;
      {zr, rr, zc, cc, rn, ct, zcr, zt, ccr, ztm, ctm, al, tc, pr, ga, pe, tmo} = '0;
      case (s)
         5'd1:  begin zr = 1; zc = 1; zcr = 1; ztm = 1; zt = 1; end
         5'd2:  rn = 1;
         5'd3:  begin zc = 1; ztm = 1; end
         5'd4:  begin al = 1; tc = 1; ctm = 1; end
         5'd5:  ctm = 1;
         5'd6:  begin cc = 1; ztm = 1; end
         5'd7:  begin zc = 1; zt = 1; end
         5'd8:  ct = t_en;
         5'd9:  rr = 1;
         5'd11: begin cc = 1; zt = 1; end
         5'd13: ccr = 1;
         5'd14: begin pr = 1; ga = 1; end
         5'd15: begin pr = 1; pe = 1; end
         5'd16: begin pr = 1; pe = 1; tmo = 1; end
         default: ;
      endcase
      return {zr, rr, zc, cc, rn, ct, zcr, zt, ccr, ztm, ctm, al, tc, pr, ga, pe, tmo};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock: queue expectation for the state entered at this edge, then compare.
   task automatic step(input logic [4:0] st);
      logic [21:0] e;
      exp_q.push_back({st, exp_outs(st, nivel_tempo_reg)});
      @(posedge clock);
      #1;
      e = exp_q.pop_front();
      chk("estado", {27'd0, db_estado}, {27'd0, e[21:17]});
      chk("saidas", {15'd0, outs}, {15'd0, e[16:0]});
      if (contaCR === 1'b1) n_cr++;
   endtask

   task automatic clear_cond();
      jogada_feita = 0; jogada_correta = 0; enderecoIgualRodada = 0;
      meioCR = 0; fimCR = 0; meioTM = 0; fimTM = 0; fimTempo = 0;
   endtask

   // From INICIO_ROD (or PROX_RODADA path) show r+1 LEDs, ending in ESPERA.
   task automatic show_round(input int r);
      for (int i = 0; i <= r; i++) begin
         clear_cond(); step(5'd4);
         step(5'd4);
         meioTM = 1; step(5'd5);
         meioTM = 0; step(5'd5);
         fimTM = 1; enderecoIgualRodada = (i == r);
         step((i == r) ? 5'd7 : 5'd6);
      end
      clear_cond();
      step(5'd8);
   endtask

   // From ESPERA accept r+1 moves; wrong_at marks the first incorrect move.
   task automatic play_moves(input int r, input int wrong_at);
      for (int j = 0; j <= r; j++) begin
         clear_cond(); step(5'd8);
         jogada_feita = 1; step(5'd9);
         jogada_feita = 0; step(5'd10);
         jogada_correta = (j != wrong_at); enderecoIgualRodada = (j == r);
         if (j == wrong_at) begin
            step(5'd15);
            clear_cond();
            return;
         end
         step((j == r) ? 5'd12 : 5'd11);
      end
      clear_cond();
   endtask

   task automatic end_round(input logic mcr, input logic fcr, input logic last);
      meioCR = mcr; fimCR = fcr;
      step(last ? 5'd14 : 5'd13);
      clear_cond();
      if (!last) step(5'd3);
   endtask

   initial begin
      reset = 0; iniciar = 0; nivel_jogadas_reg = 0; nivel_tempo_reg = 0;
      clear_cond();

      // T1: reset state, then idle with iniciar low
      #1;
      chk("reset_estado", {27'd0, db_estado}, 32'd0);
      chk("reset_saidas", {15'd0, outs}, 32'd0);
      repeat (3) @(posedge clock);
      #2 reset = 1;
      repeat (20) step(5'd0);

      // T2 + T3: 8-round game, iniciar held high throughout (ignored mid-game)
      n_cr = 0;
      iniciar = 1;
      step(5'd1); step(5'd2); step(5'd3);
      for (int r = 0; r < 8; r++) begin
         show_round(r);
         play_moves(r, -1);
         // fimCR high in round 3 must not end an 8-round game
         end_round(r == 7, r == 3, r == 7);
      end
      iniciar = 0;
      step(5'd14);
      chk("contaCR_pulsos", n_cr, 32'd7);
      chk("ganhou", {31'd0, ganhou}, 32'd1);

      // T4: 16-round game, wrong second move in round 2
      iniciar = 1; nivel_jogadas_reg = 1;
      step(5'd1);
      iniciar = 0;
      step(5'd2); step(5'd3);
      show_round(0); play_moves(0, -1); end_round(1'b1, 1'b0, 1'b0);
      show_round(1); play_moves(1, -1); end_round(1'b0, 1'b0, 1'b0);
      show_round(2); play_moves(2, 1);
      chk("errou_perdeu", {31'd0, perdeu}, 32'd1);
      chk("errou_timeout", {31'd0, timeout}, 32'd0);
      step(5'd15);
      iniciar = 1; step(5'd1);
      iniciar = 0;

      // T5/T6: timeout enabled; press and timeout together favour the press
      nivel_jogadas_reg = 0; nivel_tempo_reg = 1;
      step(5'd2); step(5'd3);
      show_round(0);
      jogada_feita = 1; fimTempo = 1; step(5'd9);
      clear_cond(); step(5'd10);
      jogada_correta = 1; enderecoIgualRodada = 1; step(5'd12);
      clear_cond(); step(5'd13); step(5'd3);
      show_round(1);
      fimTempo = 0; step(5'd8);
      fimTempo = 1; step(5'd16);
      clear_cond();
      chk("timeout_flag", {31'd0, timeout}, 32'd1);
      step(5'd16);

      // Timeout disabled: fimTempo in ESPERA must not leave the state
      nivel_tempo_reg = 0;
      iniciar = 1; step(5'd1);
      iniciar = 0; step(5'd2); step(5'd3);
      show_round(0);
      fimTempo = 1; step(5'd8); step(5'd8); step(5'd8);
      clear_cond();
      play_moves(0, -1);
      end_round(1'b0, 1'b0, 1'b0);
      step(5'd4);
      chk("mostra_toca", {31'd0, toca}, 32'd1);

      // Async reset in MOSTRA: outputs drop without a clock edge
      #2 reset = 0;
      #1;
      chk("async_estado", {27'd0, db_estado}, 32'd0);
      chk("async_toca", {31'd0, toca}, 32'd0);
      chk("async_leds", {31'd0, ativa_leds}, 32'd0);
      @(negedge clock);
      reset = 1;
      step(5'd0); step(5'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
